// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pacman_pkg
// Brief    : Shared game-state encoding, key codes and scoring constants for
//            the Pacman game controller.
// Revision : 1.0 - initial release
// ============================================================================
package pacman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_PAUSE     = 3'd2,
    ST_DYING     = 3'd3,
    ST_LEVEL_UP  = 3'd4,
    ST_GAME_OVER = 3'd5,
    ST_WIN       = 3'd6
  } game_state_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_P     = 8'h13;

  localparam int PTS_PELLET    = 10;
  localparam int PTS_POWER     = 50;
  localparam int PTS_GHOST     = 200;
  localparam int FRIGHT_FRAMES = 300;

endpackage
`default_nettype wire

// File: rtl/pacman_game_ctrl_ghost_hit_det.sv
`default_nettype none
// ============================================================================
// Module   : ghost_hit_det
// Brief    : Per-ghost bounding-box overlap test against Pacman. Purely
//            combinational; sums and differences are 11 bits so large
//            half-sizes never wrap.
// Revision : 1.0 - initial release
// ============================================================================
module ghost_hit_det #(
  parameter int NUM_GHOSTS = 2
) (
  input  logic [9:0]              i_pac_x,
  input  logic [9:0]              i_pac_y,
  input  logic [9:0]              i_pac_s,
  input  logic [10*NUM_GHOSTS-1:0] i_ghost_x,
  input  logic [10*NUM_GHOSTS-1:0] i_ghost_y,
  input  logic [10*NUM_GHOSTS-1:0] i_ghost_s,
  output logic [NUM_GHOSTS-1:0]   o_hit
);

  generate
    for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
      logic [10:0] w_px, w_py, w_ps, w_gx, w_gy, w_gs;
      logic [10:0] w_dx, w_dy, w_sum;

      assign w_px  = {1'b0, i_pac_x};
      assign w_py  = {1'b0, i_pac_y};
      assign w_ps  = {1'b0, i_pac_s};
      assign w_gx  = {1'b0, i_ghost_x[10*gi +: 10]};
      assign w_gy  = {1'b0, i_ghost_y[10*gi +: 10]};
      assign w_gs  = {1'b0, i_ghost_s[10*gi +: 10]};

      // Absolute distances and combined half-size; strict '<' so touching edges do not collide
      assign w_dx  = (w_px >= w_gx) ? (w_px - w_gx) : (w_gx - w_px);
      assign w_dy  = (w_py >= w_gy) ? (w_py - w_gy) : (w_gy - w_py);
      assign w_sum = w_ps + w_gs;

      assign o_hit[gi] = (w_dx < w_sum) && (w_dy < w_sum);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pacman_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pacman_game_ctrl
// Brief    : Game-state controller: N-ghost collision, lives, levels, score,
//            pause, and entity/board reset + freeze for movers and maps.
//            Optional macro PACMAN_POWERUP_EN adds power pellets,
//            frightened mode and per-ghost respawn pulses.
// Revision : 1.0 - initial release
// ============================================================================
module pacman_game_ctrl
  import pacman_pkg::*;
#(
  parameter int NUM_GHOSTS     = 2,
  parameter int NUM_LEVELS     = 4,
  parameter int LIVES          = 3,
  parameter int PELLETS        = 96,
  parameter int DEATH_FRAMES   = 60,
  parameter int LEVELUP_FRAMES = 90,
  parameter int SCORE_W        = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    vs,
  input  logic [7:0]              keycode,
  input  logic [9:0]              pac_x,
  input  logic [9:0]              pac_y,
  input  logic [9:0]              pac_s,
  input  logic [10*NUM_GHOSTS-1:0] ghost_x,
  input  logic [10*NUM_GHOSTS-1:0] ghost_y,
  input  logic [10*NUM_GHOSTS-1:0] ghost_s,
  input  logic                    pellet_eaten,
`ifdef PACMAN_POWERUP_EN
  input  logic                    power_pellet,
  output logic                    frightened,
  output logic [NUM_GHOSTS-1:0]   ghost_respawn,
`endif
  output logic [2:0]              state,
  output logic [1:0]              level,
  output logic [2:0]              lives,
  output logic [SCORE_W-1:0]      score,
  output logic                    freeze,
  output logic                    entity_rst,
  output logic                    board_rst
);

  localparam int c_PC_W      = $clog2(PELLETS + 1);
  localparam int c_FRAME_MAX = (DEATH_FRAMES > LEVELUP_FRAMES) ? DEATH_FRAMES : LEVELUP_FRAMES;
  localparam int c_FC_W      = $clog2(c_FRAME_MAX + 1);

  localparam logic [c_PC_W-1:0] c_PELLETS    = c_PC_W'(PELLETS);
  localparam logic [c_FC_W-1:0] c_DEATH_LAST = c_FC_W'(DEATH_FRAMES - 1);
  localparam logic [c_FC_W-1:0] c_LVUP_LAST  = c_FC_W'(LEVELUP_FRAMES - 1);
  localparam logic [1:0]        c_LAST_LVL   = 2'(NUM_LEVELS - 1);
  localparam logic [2:0]        c_LIVES      = 3'(LIVES);

  game_state_t         r_state;
  logic [1:0]          r_level;
  logic [2:0]          r_lives;
  logic [SCORE_W-1:0]  r_score;
  logic [c_PC_W-1:0]   r_pellet_cnt;
  logic [c_FC_W-1:0]   r_frame_cnt;
  logic                r_freeze;
  logic                r_entity_rst;
  logic                r_board_rst;
  logic                r_vs_q;
  logic                r_tick;
  logic [7:0]          r_key_prev;

  logic [NUM_GHOSTS-1:0] w_hit;
  logic                w_enter_edge;
  logic                w_p_edge;
  logic                w_tick_play;
  logic                w_level_clear;
  logic                w_kill;
  logic                w_eat;
  logic [31:0]         w_pts;
  logic [SCORE_W:0]    w_score_sum;
  logic [SCORE_W-1:0]  w_score_sat;

  ghost_hit_det #(
    .NUM_GHOSTS (NUM_GHOSTS)
  ) u_hit (
    .i_pac_x   (pac_x),
    .i_pac_y   (pac_y),
    .i_pac_s   (pac_s),
    .i_ghost_x (ghost_x),
    .i_ghost_y (ghost_y),
    .i_ghost_s (ghost_s),
    .o_hit     (w_hit)
  );

  // Keys act only on a transition out of "no key", so a held key never repeats
  assign w_enter_edge  = (keycode == KEY_ENTER) && (r_key_prev == 8'h00);
  assign w_p_edge      = (keycode == KEY_P)     && (r_key_prev == 8'h00);
  // A pause request in the same Clk as a frame tick takes priority over the tick
  assign w_tick_play   = (r_state == ST_PLAY) && r_tick && !w_p_edge;
  assign w_level_clear = (r_pellet_cnt == c_PELLETS);

`ifdef PACMAN_POWERUP_EN
  localparam int c_FR_W = $clog2(FRIGHT_FRAMES);
  localparam logic [c_FR_W-1:0] c_FRIGHT_LAST = c_FR_W'(FRIGHT_FRAMES - 1);

  logic                  r_fright;
  logic [c_FR_W-1:0]     r_fright_cnt;
  logic [NUM_GHOSTS-1:0] r_respawn;
  logic                  w_ghost_eat;

  assign w_ghost_eat = w_tick_play && !w_level_clear && r_fright && (|w_hit);
  assign w_kill      = w_tick_play && !w_level_clear && !r_fright && (|w_hit);
`else
  assign w_kill      = w_tick_play && !w_level_clear && (|w_hit);
`endif

  // Points earned this Clk (only applied while in PLAY)
  always_comb begin
    w_pts = 32'd0;
    w_eat = pellet_eaten;
    if (pellet_eaten) w_pts = w_pts + PTS_PELLET;
`ifdef PACMAN_POWERUP_EN
    w_eat = pellet_eaten | power_pellet;
    if (power_pellet) w_pts = w_pts + PTS_POWER;
    if (w_ghost_eat)  w_pts = w_pts + PTS_GHOST * $countones(w_hit);
`endif
  end

  // Score adds with one guard bit and clamps to all-ones
  assign w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(w_pts);
  assign w_score_sat = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

  // Input edge detection: registered VS falling edge gives a 1-Clk frame tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vs_q     <= 1'b0;
      r_tick     <= 1'b0;
      r_key_prev <= 8'h00;
    end else begin
      r_vs_q     <= vs;
      r_tick     <= r_vs_q & ~vs;
      r_key_prev <= keycode;
    end
  end

  // Game FSM with its counters and registered control outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_level      <= 2'd0;
      r_lives      <= c_LIVES;
      r_score      <= '0;
      r_pellet_cnt <= '0;
      r_frame_cnt  <= '0;
      r_freeze     <= 1'b1;
      r_entity_rst <= 1'b1;
      r_board_rst  <= 1'b0;
`ifdef PACMAN_POWERUP_EN
      r_fright     <= 1'b0;
      r_fright_cnt <= '0;
      r_respawn    <= '0;
`endif
    end else begin
      r_board_rst <= 1'b0;

      // Pellets count in PLAY, including the Clk in which PLAY is left
      if (r_state == ST_PLAY) begin
        if (w_pts != 32'd0) r_score <= w_score_sat;
        if (w_eat && !w_level_clear) r_pellet_cnt <= r_pellet_cnt + c_PC_W'(1);
      end

`ifdef PACMAN_POWERUP_EN
      r_respawn <= '0;
      if (r_state == ST_PLAY) begin
        if (power_pellet) begin
          r_fright     <= 1'b1;
          r_fright_cnt <= '0;
        end else if (r_fright && w_tick_play) begin
          if (r_fright_cnt == c_FRIGHT_LAST) r_fright <= 1'b0;
          else r_fright_cnt <= r_fright_cnt + c_FR_W'(1);
        end
        if (w_ghost_eat) r_respawn <= w_hit;
        if (w_tick_play && (w_level_clear || w_kill)) r_fright <= 1'b0;
      end else if (r_state != ST_PAUSE) begin
        r_fright <= 1'b0;
      end
`endif

      case (r_state)
        ST_IDLE: begin
          r_entity_rst <= 1'b1;
          r_freeze     <= 1'b1;
          if (w_enter_edge) begin
            r_state      <= ST_PLAY;
            r_freeze     <= 1'b0;
            r_entity_rst <= 1'b0;
            r_board_rst  <= 1'b1;
            r_lives      <= c_LIVES;
            r_level      <= 2'd0;
            r_score      <= '0;
            r_pellet_cnt <= '0;
            r_frame_cnt  <= '0;
          end
        end

        ST_PLAY: begin
          r_entity_rst <= 1'b0;
          if (w_p_edge) begin
            r_state  <= ST_PAUSE;
            r_freeze <= 1'b1;
          end else if (w_tick_play && w_level_clear) begin
            r_state     <= ST_LEVEL_UP;
            r_freeze    <= 1'b1;
            r_frame_cnt <= '0;
          end else if (w_kill) begin
            r_state     <= ST_DYING;
            r_freeze    <= 1'b1;
            r_frame_cnt <= '0;
          end
        end

        ST_PAUSE: begin
          if (w_p_edge) begin
            r_state  <= ST_PLAY;
            r_freeze <= 1'b0;
          end
        end

        ST_DYING: begin
          if (r_tick) begin
            if (r_frame_cnt == c_DEATH_LAST) begin
              r_lives      <= r_lives - 3'd1;
              r_entity_rst <= 1'b1;
              if (r_lives == 3'd1) begin
                r_state <= ST_GAME_OVER;
              end else begin
                r_state  <= ST_PLAY;
                r_freeze <= 1'b0;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + c_FC_W'(1);
            end
          end
        end

        ST_LEVEL_UP: begin
          if (r_tick) begin
            if (r_frame_cnt == c_LVUP_LAST) begin
              r_entity_rst <= 1'b1;
              if (r_level == c_LAST_LVL) begin
                r_state <= ST_WIN;
              end else begin
                r_state      <= ST_PLAY;
                r_freeze     <= 1'b0;
                r_level      <= r_level + 2'd1;
                r_pellet_cnt <= '0;
                r_board_rst  <= 1'b1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + c_FC_W'(1);
            end
          end
        end

        ST_GAME_OVER, ST_WIN: begin
          r_entity_rst <= 1'b1;
          r_freeze     <= 1'b1;
          if (w_enter_edge) r_state <= ST_IDLE;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_freeze     <= 1'b1;
          r_entity_rst <= 1'b1;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign level      = r_level;
  assign lives      = r_lives;
  assign score      = r_score;
  assign freeze     = r_freeze;
  assign entity_rst = r_entity_rst;
  assign board_rst  = r_board_rst;
`ifdef PACMAN_POWERUP_EN
  assign frightened    = r_fright;
  assign ghost_respawn = r_respawn;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pacman_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pacman_game_ctrl
// Brief    : Self-checking bench for pacman_game_ctrl (default parameters).
//            Collision cases come from a vector table; lives, levels, pause
//            and reset are hand-written sequences. Expected outputs are
//            queued when stimulus is applied and popped when checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pacman_game_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_PAUSE = 3'd2, S_DYING = 3'd3,
                         S_LVUP = 3'd4, S_OVER = 3'd5, S_WIN = 3'd6;
  localparam logic [7:0] K_ENTER = 8'h28, K_P = 8'h13;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        vs = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic [9:0]  pac_x = 10'd100, pac_y = 10'd100, pac_s = 10'd6;
  logic [19:0] ghost_x = '0, ghost_y = '0, ghost_s = '0;
  logic        pellet_eaten = 1'b0;
  logic [2:0]  state;
  logic [1:0]  level;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        freeze, entity_rst, board_rst;
`ifdef PACMAN_POWERUP_EN
  logic        power_pellet = 1'b0;
  logic        frightened;
  logic [1:0]  ghost_respawn;
`endif

  pacman_game_ctrl #(
    .NUM_GHOSTS(2), .NUM_LEVELS(4), .LIVES(3), .PELLETS(96),
    .DEATH_FRAMES(60), .LEVELUP_FRAMES(90), .SCORE_W(16)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .keycode(keycode),
    .pac_x(pac_x), .pac_y(pac_y), .pac_s(pac_s),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_s(ghost_s),
    .pellet_eaten(pellet_eaten),
`ifdef PACMAN_POWERUP_EN
    .power_pellet(power_pellet), .frightened(frightened), .ghost_respawn(ghost_respawn),
`endif
    .state(state), .level(level), .lives(lives), .score(score),
    .freeze(freeze), .entity_rst(entity_rst), .board_rst(board_rst)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Pulse/transition monitors sampled on the falling edge
  int br_cnt = 0, er_cnt = 0, pause_cnt = 0;
  logic [2:0] last_st = 3'd0;
`ifdef PACMAN_POWERUP_EN
  int resp_cnt = 0;
  logic [1:0] resp_last = 2'b00;
`endif
  always @(negedge Clk) begin
    if (board_rst)  br_cnt++;
    if (entity_rst) er_cnt++;
    if (state == S_PAUSE && last_st != S_PAUSE) pause_cnt++;
    last_st = state;
`ifdef PACMAN_POWERUP_EN
    if (ghost_respawn != 2'b00) begin
      resp_cnt++;
      resp_last = ghost_respawn;
    end
`endif
  end

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [1:0]  lvl;
    logic [2:0]  lv;
    logic [15:0] sc;
    logic        fz;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [9:0] px, py, ps, g0x, g0y, g0s, g1x, g1y, g1s;
    logic [2:0] exp_st;
  } hv_t;
  hv_t tbl[9];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic sb_push(input string n, input logic [2:0] st, input logic [1:0] lvl,
                         input logic [2:0] lv, input logic [15:0] sc, input logic fz);
    exp_t e;
    e.name = n; e.st = st; e.lvl = lvl; e.lv = lv; e.sc = sc; e.fz = fz;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, ".state"},  32'(state),  32'(e.st));
    chk({e.name, ".level"},  32'(level),  32'(e.lvl));
    chk({e.name, ".lives"},  32'(lives),  32'(e.lv));
    chk({e.name, ".score"},  32'(score),  32'(e.sc));
    chk({e.name, ".freeze"}, 32'(freeze), 32'(e.fz));
  endtask

  task automatic tick_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    tick_clk(1);
    keycode = 8'h00;
    tick_clk(1);
  endtask

  task automatic frame_tick();
    vs = 1'b0;
    tick_clk(2);
    vs = 1'b1;
    tick_clk(2);
  endtask

  task automatic eat(input int n);
    repeat (n) begin
      pellet_eaten = 1'b1;
      tick_clk(1);
      pellet_eaten = 1'b0;
      tick_clk(1);
    end
  endtask

  task automatic set_pos(input logic [9:0] px, py, ps, g0x, g0y, g0s, g1x, g1y, g1s);
    pac_x = px; pac_y = py; pac_s = ps;
    ghost_x = {g1x, g0x}; ghost_y = {g1y, g0y}; ghost_s = {g1s, g0s};
  endtask

  task automatic ghosts_far();
    set_pos(10'd100, 10'd100, 10'd6, 10'd900, 10'd900, 10'd1, 10'd900, 10'd800, 10'd1);
  endtask

  task automatic restart();
    Reset_n = 1'b0;
    tick_clk(2);
    Reset_n = 1'b1;
    tick_clk(1);
    press(K_ENTER);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, e0, p0;

    tbl[0] = '{10'd100, 10'd100, 10'd6, 10'd112, 10'd100, 10'd6, 10'd900, 10'd800, 10'd1, S_PLAY};
    tbl[1] = '{10'd100, 10'd100, 10'd6, 10'd111, 10'd100, 10'd6, 10'd900, 10'd800, 10'd1, S_DYING};
    tbl[2] = '{10'd100, 10'd100, 10'd6, 10'd89,  10'd100, 10'd6, 10'd900, 10'd800, 10'd1, S_DYING};
    tbl[3] = '{10'd100, 10'd100, 10'd6, 10'd88,  10'd100, 10'd6, 10'd900, 10'd800, 10'd1, S_PLAY};
    tbl[4] = '{10'd100, 10'd100, 10'd6, 10'd100, 10'd112, 10'd6, 10'd900, 10'd800, 10'd1, S_PLAY};
    tbl[5] = '{10'd100, 10'd100, 10'd6, 10'd100, 10'd89,  10'd6, 10'd900, 10'd800, 10'd1, S_DYING};
    tbl[6] = '{10'd100, 10'd100, 10'd6, 10'd900, 10'd900, 10'd1, 10'd105, 10'd95,  10'd3, S_DYING};
    tbl[7] = '{10'd100, 10'd100, 10'd600, 10'd400, 10'd100, 10'd600, 10'd900, 10'd900, 10'd1, S_DYING};
    tbl[8] = '{10'd100, 10'd100, 10'd6, 10'd110, 10'd200, 10'd6, 10'd200, 10'd100, 10'd6, S_PLAY};

    ghosts_far();

    // Reset values
    tick_clk(3);
    sb_push("reset", S_IDLE, 2'd0, 3'd3, 16'd0, 1'b1);
    sb_check();
    chk("reset.entity_rst", 32'(entity_rst), 32'd1);
    chk("reset.board_rst",  32'(board_rst),  32'd0);
    Reset_n = 1'b1;
    tick_clk(2);

    // Start: board_rst one Clk, entity_rst drops
    b0 = br_cnt;
    press(K_ENTER);
    sb_push("start", S_PLAY, 2'd0, 3'd3, 16'd0, 1'b0);
    sb_check();
    chk("start.board_rst_pulses", 32'(br_cnt - b0), 32'd1);
    chk("start.entity_rst", 32'(entity_rst), 32'd0);

    // Death and respawn
    set_pos(10'd100, 10'd100, 10'd6, 10'd110, 10'd100, 10'd6, 10'd900, 10'd800, 10'd1);
    frame_tick();
    sb_push("hit", S_DYING, 2'd0, 3'd3, 16'd0, 1'b1);
    sb_check();
    repeat (59) frame_tick();
    sb_push("dying59", S_DYING, 2'd0, 3'd3, 16'd0, 1'b1);
    sb_check();
    e0 = er_cnt;
    frame_tick();
    sb_push("respawn", S_PLAY, 2'd0, 3'd2, 16'd0, 1'b0);
    sb_check();
    chk("respawn.entity_rst_pulses", 32'(er_cnt - e0), 32'd1);

    // Remaining deaths to game over (ghost still overlapping)
    frame_tick();
    repeat (60) frame_tick();
    sb_push("death2", S_PLAY, 2'd0, 3'd1, 16'd0, 1'b0);
    sb_check();
    frame_tick();
    repeat (60) frame_tick();
    sb_push("gameover", S_OVER, 2'd0, 3'd0, 16'd0, 1'b1);
    sb_check();
    chk("gameover.entity_rst", 32'(entity_rst), 32'd1);
    press(K_ENTER);
    tick_clk(4);
    sb_push("over_to_idle", S_IDLE, 2'd0, 3'd0, 16'd0, 1'b1);
    sb_check();
    chk("idle.entity_rst", 32'(entity_rst), 32'd1);

    // Collision vector table
    for (int i = 0; i < 9; i++) begin
      ghosts_far();
      restart();
      set_pos(tbl[i].px, tbl[i].py, tbl[i].ps, tbl[i].g0x, tbl[i].g0y, tbl[i].g0s,
              tbl[i].g1x, tbl[i].g1y, tbl[i].g1s);
      frame_tick();
      sb_push($sformatf("hitvec%0d", i), tbl[i].exp_st, 2'd0, 3'd3, 16'd0, tbl[i].exp_st != S_PLAY);
      sb_check();
    end

    // Levels through to WIN
    ghosts_far();
    restart();
    for (int lv = 0; lv < 4; lv++) begin
      eat(95);
      frame_tick();
      sb_push($sformatf("lvl%0d_95", lv), S_PLAY, 2'(lv), 3'd3, 16'(960 * lv + 950), 1'b0);
      sb_check();
      eat(1);
      sb_push($sformatf("lvl%0d_96", lv), S_PLAY, 2'(lv), 3'd3, 16'(960 * (lv + 1)), 1'b0);
      sb_check();
      frame_tick();
      sb_push($sformatf("lvl%0d_clear", lv), S_LVUP, 2'(lv), 3'd3, 16'(960 * (lv + 1)), 1'b1);
      sb_check();
      repeat (89) frame_tick();
      sb_push($sformatf("lvl%0d_wait", lv), S_LVUP, 2'(lv), 3'd3, 16'(960 * (lv + 1)), 1'b1);
      sb_check();
      b0 = br_cnt;
      e0 = er_cnt;
      frame_tick();
      if (lv < 3) begin
        sb_push($sformatf("lvl%0d_next", lv), S_PLAY, 2'(lv + 1), 3'd3, 16'(960 * (lv + 1)), 1'b0);
        sb_check();
        chk($sformatf("lvl%0d.board_rst_pulses", lv),  32'(br_cnt - b0), 32'd1);
        chk($sformatf("lvl%0d.entity_rst_pulses", lv), 32'(er_cnt - e0), 32'd1);
      end else begin
        sb_push("win", S_WIN, 2'd3, 3'd3, 16'd3840, 1'b1);
        sb_check();
        chk("win.entity_rst", 32'(entity_rst), 32'd1);
      end
    end
    press(K_ENTER);
    sb_push("win_to_idle", S_IDLE, 2'd3, 3'd3, 16'd3840, 1'b1);
    sb_check();
    press(K_ENTER);
    sb_push("replay", S_PLAY, 2'd0, 3'd3, 16'd0, 1'b0);
    sb_check();

    // Held P gives one pause; pellets and hits ignored while paused
    p0 = pause_cnt;
    keycode = K_P;
    tick_clk(10);
    keycode = 8'h00;
    tick_clk(1);
    chk("pause.entries", 32'(pause_cnt - p0), 32'd1);
    eat(3);
    set_pos(10'd100, 10'd100, 10'd6, 10'd110, 10'd100, 10'd6, 10'd900, 10'd800, 10'd1);
    frame_tick();
    sb_push("paused", S_PAUSE, 2'd0, 3'd3, 16'd0, 1'b1);
    sb_check();
    ghosts_far();
    press(K_P);
    eat(1);
    sb_push("unpause", S_PLAY, 2'd0, 3'd3, 16'd10, 1'b0);
    sb_check();

    // Asynchronous reset mid-game, checked before any further clock edge
    #2;
    Reset_n = 1'b0;
    #1;
    sb_push("async_rst", S_IDLE, 2'd0, 3'd3, 16'd0, 1'b1);
    sb_check();
    chk("async_rst.entity_rst", 32'(entity_rst), 32'd1);
    chk("async_rst.board_rst",  32'(board_rst),  32'd0);
    #1;
    Reset_n = 1'b1;
    tick_clk(2);

`ifdef PACMAN_POWERUP_EN
    // Power pellet: frightened hit scores and respawns instead of killing
    ghosts_far();
    restart();
    power_pellet = 1'b1;
    tick_clk(1);
    power_pellet = 1'b0;
    tick_clk(1);
    chk("power.frightened", 32'(frightened), 32'd1);
    p0 = resp_cnt;
    set_pos(10'd100, 10'd100, 10'd6, 10'd900, 10'd900, 10'd1, 10'd105, 10'd100, 10'd6);
    frame_tick();
    sb_push("fright_hit", S_PLAY, 2'd0, 3'd3, 16'd250, 1'b0);
    sb_check();
    chk("fright_hit.respawn_pulses", 32'(resp_cnt - p0), 32'd1);
    chk("fright_hit.respawn_val", 32'(resp_last), 32'd2);
    ghosts_far();
    repeat (298) frame_tick();
    chk("fright.tick299", 32'(frightened), 32'd1);
    frame_tick();
    chk("fright.tick300", 32'(frightened), 32'd0);
    set_pos(10'd100, 10'd100, 10'd6, 10'd900, 10'd900, 10'd1, 10'd105, 10'd100, 10'd6);
    frame_tick();
    sb_push("fright_over_hit", S_DYING, 2'd0, 3'd3, 16'd250, 1'b1);
    sb_check();
`endif

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
